// File: rtl/execute_pkg.sv
// execute_pkg: definitions shared by the execute stage.
//   - DEFAULT_XLEN      : default datapath / PC / immediate width
//   - OP_*              : 4-bit ALU operation codes driven on alu_control_signal
//   - BR_*              : 2-bit branch condition codes driven on branch_cond
//   - state_t           : execute FSM states (ST_MUL_BUSY is only reached when
//                         the design is built with EXECUTE_PIPE_MUL_EN)
package execute_pkg;

    localparam int DEFAULT_XLEN = 64;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_GE = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/execute_alu.sv
// execute_alu: purely combinational single-cycle ALU.
//   alu_control_signal in  4     operation select (OP_* codes)
//   op_a, op_b         in  XLEN  operands
//   result             out XLEN  operation result; OP_MUL and every
//                                undefined code give zero (multiply is
//                                handled iteratively by execute_pipe)
// Shifts use the low log2(XLEN) bits of op_b; add/sub wrap modulo 2^XLEN.
module execute_alu
    import execute_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [3:0]      alu_control_signal,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt_s;

    assign shamt_s = op_b[SHW-1:0];

    // Operation decode.
    always_comb begin
        result = '0;
        case (alu_control_signal)
            OP_ADD:  result = op_a + op_b;
            OP_SLL:  result = op_a << shamt_s;
            OP_SUB:  result = op_a - op_b;
            OP_AND:  result = op_a & op_b;
            OP_OR:   result = op_a | op_b;
            OP_XOR:  result = op_a ^ op_b;
            OP_SRL:  result = op_a >> shamt_s;
            OP_SRA:  result = $unsigned($signed(op_a) >>> shamt_s);
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: execute stage with valid/ready handshakes on both sides.
// Single-cycle ALU/branch operations are registered (latency 1). When built
// with the macro EXECUTE_PIPE_MUL_EN, opcode OP_MUL runs an iterative
// shift-add multiply (one multiplier bit per cycle, XLEN cycles) in state
// ST_MUL_BUSY; without the macro OP_MUL simply returns 0 with latency 1.
// Ports:
//   clk, reset           in   clock, synchronous active-high reset
//   in_valid / in_ready  in/out upstream handshake
//   alu_control_signal   in   4-bit operation select
//   rd1, rd2             in   XLEN operands (also the branch comparands)
//   PC, immediate        in   XLEN operation PC and sign-extended immediate
//   Branch, branch_cond  in   conditional branch flag and condition code
//   flush                in   drop everything in flight and held
//   out_valid/out_ready  out/in downstream handshake
//   alu_output, next_PC  out  XLEN registered results
//   branch_taken         out  registered branch decision
module execute_pipe
    import execute_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int PC_STEP   = 4,
    parameter int IMM_SHIFT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_control_signal,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] immediate,
    input  logic            Branch,
    input  logic [1:0]      branch_cond,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_output,
    output logic [XLEN-1:0] next_PC,
    output logic            branch_taken
);

    localparam logic [XLEN-1:0] PC_STEP_X = XLEN'(PC_STEP);

    state_t          state_r;
    state_t          state_next_s;
    logic            out_valid_r;
    logic [XLEN-1:0] alu_output_r;
    logic [XLEN-1:0] next_pc_r;
    logic            branch_taken_r;

    logic            in_ready_s;
    logic            accept_s;
    logic [XLEN-1:0] alu_result_s;
    logic            cond_true_s;
    logic            branch_taken_s;
    logic [XLEN-1:0] seq_pc_s;
    logic [XLEN-1:0] target_pc_s;
    logic [XLEN-1:0] next_pc_s;

`ifdef EXECUTE_PIPE_MUL_EN
    localparam int CW = $clog2(XLEN) + 1;

    logic [XLEN-1:0] mcand_r;
    logic [XLEN-1:0] mplier_r;
    logic [XLEN-1:0] acc_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] mul_pc_r;
    logic [XLEN-1:0] addend_s;
    logic [XLEN-1:0] product_s;
    logic            mul_start_s;
    logic            mul_last_s;
`endif

    execute_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .alu_control_signal(alu_control_signal),
        .op_a              (rd1),
        .op_b              (rd2),
        .result            (alu_result_s)
    );

    // Branch condition evaluation on rd1 versus rd2.
    always_comb begin
        cond_true_s = 1'b0;
        case (branch_cond)
            BR_EQ:   cond_true_s = (rd1 == rd2);
            BR_NE:   cond_true_s = (rd1 != rd2);
            BR_LT:   cond_true_s = ($signed(rd1) <  $signed(rd2));
            BR_GE:   cond_true_s = ($signed(rd1) >= $signed(rd2));
            default: cond_true_s = 1'b0;
        endcase
    end

    assign branch_taken_s = Branch & cond_true_s;
    assign seq_pc_s       = PC + PC_STEP_X;
    assign target_pc_s    = PC + (immediate << IMM_SHIFT);

    // Next-PC select between taken target and sequential successor.
    always_comb begin
        next_pc_s = seq_pc_s;
        if (branch_taken_s) begin
            next_pc_s = target_pc_s;
        end else begin
            next_pc_s = seq_pc_s;
        end
    end

    // FSM output process: accept only when idle and the output slot frees up.
    always_comb begin
        in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready);
    end

    assign in_ready = in_ready_s;
    // A flushed cycle never accepts: the presented operation is dropped.
    assign accept_s = in_valid & in_ready_s & ~flush;

`ifdef EXECUTE_PIPE_MUL_EN
    assign mul_start_s = accept_s && (alu_control_signal == OP_MUL);
    // The last of XLEN steps writes the product straight into the output register.
    assign mul_last_s  = (state_r == ST_MUL_BUSY) && (cnt_r == CW'(XLEN - 1)) && !flush;
    assign addend_s    = mplier_r[0] ? mcand_r : '0;
    assign product_s   = acc_r + addend_s;
`endif

    // FSM next-state process; flush always returns to idle.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_IDLE;
        end else begin
`ifdef EXECUTE_PIPE_MUL_EN
            case (state_r)
                ST_IDLE: begin
                    if (mul_start_s) begin
                        state_next_s = ST_MUL_BUSY;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_last_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_MUL_BUSY;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
`else
            state_next_s = ST_IDLE;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

`ifdef EXECUTE_PIPE_MUL_EN
    // Shift-add multiplier: multiplicand moves left, multiplier moves right.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            cnt_r    <= '0;
            mul_pc_r <= '0;
        end else if (mul_start_s) begin
            mcand_r  <= rd1;
            mplier_r <= rd2;
            acc_r    <= '0;
            cnt_r    <= '0;
            mul_pc_r <= seq_pc_s;
        end else if (state_r == ST_MUL_BUSY) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= product_s;
            cnt_r    <= cnt_r + CW'(1);
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
            mul_pc_r <= mul_pc_r;
        end
    end
`endif

    // Output register: holds while stalled, cleared by flush or consumption.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r    <= 1'b0;
            alu_output_r   <= '0;
            next_pc_r      <= '0;
            branch_taken_r <= 1'b0;
        end else if (flush) begin
            out_valid_r    <= 1'b0;
`ifdef EXECUTE_PIPE_MUL_EN
        end else if (mul_last_s) begin
            out_valid_r    <= 1'b1;
            alu_output_r   <= product_s;
            next_pc_r      <= mul_pc_r;
            branch_taken_r <= 1'b0;
        end else if (accept_s && !mul_start_s) begin
`else
        end else if (accept_s) begin
`endif
            out_valid_r    <= 1'b1;
            alu_output_r   <= alu_result_s;
            next_pc_r      <= next_pc_s;
            branch_taken_r <= branch_taken_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r    <= 1'b0;
        end else begin
            out_valid_r    <= out_valid_r;
        end
    end

    assign out_valid    = out_valid_r;
    assign alu_output   = alu_output_r;
    assign next_PC      = next_pc_r;
    assign branch_taken = branch_taken_r;

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed self-checking bench for execute_pipe (XLEN=64).
// Multiply scenarios are compiled only with EXECUTE_PIPE_MUL_EN defined.
module tb_execute_pipe;

    localparam int XLEN = 64;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_control_signal;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] immediate;
    logic            Branch;
    logic [1:0]      branch_cond;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_output;
    logic [XLEN-1:0] next_PC;
    logic            branch_taken;

    int vectors;
    int miscompares;

    execute_pipe #(.XLEN(XLEN), .PC_STEP(4), .IMM_SHIFT(1)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .alu_control_signal(alu_control_signal),
        .rd1               (rd1),
        .rd2               (rd2),
        .PC                (PC),
        .immediate         (immediate),
        .Branch            (Branch),
        .branch_cond       (branch_cond),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .alu_output        (alu_output),
        .next_PC           (next_PC),
        .branch_taken      (branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] pc, input logic [63:0] imm,
                         input logic br, input logic [1:0] cond);
        in_valid           = 1'b1;
        alu_control_signal = op;
        rd1                = a;
        rd2                = b;
        PC                 = pc;
        immediate          = imm;
        Branch             = br;
        branch_cond        = cond;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(4'b0000, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 2'b00);
        in_valid = 1'b0;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0 || alu_output !== 64'd0 || next_PC !== 64'd0 || branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b alu=%h pc=%h bt=%b, need all zero",
                     out_valid, alu_output, next_PC, branch_taken);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b need 1", in_ready);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [13] = '{4'b0000, 4'b0010, 4'b0001, 4'b0111, 4'b0110, 4'b0011, 4'b0100,
                                   4'b0101, 4'b1000, 4'b1001, 4'b0000, 4'b1111, 4'b1011};
        logic [63:0] av [13] = '{64'd5, 64'd5, 64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                                  64'hF0F0, 64'hF0F0, 64'hF0F0, 64'hFFFF_FFFF_FFFF_FFFF,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 64'd9};
        logic [63:0] bv [13] = '{64'd7, 64'd7, 64'h43, 64'd4, 64'd4, 64'hFF00, 64'hFF00, 64'hFF00,
                                  64'd1, 64'd1, 64'd1, 64'd3, 64'd3};
        logic [63:0] ev [13] = '{64'd12, 64'hFFFF_FFFF_FFFF_FFFE, 64'd8, 64'hF800_0000_0000_0000,
                                  64'h0800_0000_0000_0000, 64'hF000, 64'hFFF0, 64'h0FF0, 64'd1, 64'd0,
                                  64'd0, 64'd0, 64'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(ops[i], av[i], bv[i], 64'h1000, 64'd0, 1'b0, 2'b00);
            tick();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || alu_output !== ev[i] || next_PC !== 64'h1004) begin
                miscompares++;
                $display("FAIL alu_op[%0d]: got v=%b alu=%h npc=%h, need v=1 alu=%h npc=1004",
                         i, out_valid, alu_output, next_PC, ev[i]);
            end
        end
`ifndef EXECUTE_PIPE_MUL_EN
        drive(4'b1010, 64'd6, 64'd7, 64'h2000, 64'd0, 1'b0, 2'b00);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || alu_output !== 64'd0) begin
            miscompares++;
            $display("FAIL mul_disabled: got v=%b alu=%h, need v=1 alu=0", out_valid, alu_output);
        end
`endif
        tick();
    endtask

    task automatic test_branch();
        logic [1:0]  cv [6] = '{2'b10, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00};
        logic        brv[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] av [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd3, 64'd3, 64'd3};
        logic [63:0] bv [6] = '{64'd1, 64'd1, 64'd3, 64'd3, 64'd3, 64'd3};
        logic [63:0] iv [6] = '{64'd8, 64'd8, 64'd8, 64'd8, 64'd8, 64'hFFFF_FFFF_FFFF_FFF8};
        logic        tk [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [63:0] np [6] = '{64'h110, 64'h104, 64'h110, 64'h104, 64'h104, 64'hF0};
        logic [63:0] al [6] = '{64'd0, 64'd0, 64'd6, 64'd6, 64'd6, 64'd6};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(4'b0000, av[i], bv[i], 64'h100, iv[i], brv[i], cv[i]);
            tick();
            in_valid = 1'b0;
            vectors++;
            if (out_valid !== 1'b1 || branch_taken !== tk[i] || next_PC !== np[i] || alu_output !== al[i]) begin
                miscompares++;
                $display("FAIL branch[%0d]: got v=%b bt=%b npc=%h alu=%h, need v=1 bt=%b npc=%h alu=%h",
                         i, out_valid, branch_taken, next_PC, alu_output, tk[i], np[i], al[i]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_seq [3] = '{64'd2, 64'd4, 64'd6};
        out_ready = 1'b0;
        drive(4'b0000, 64'd1, 64'd1, 64'h0, 64'd0, 1'b0, 2'b00);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_ready: got %b need 1", in_ready);
        end
        tick();
        drive(4'b0000, 64'd2, 64'd2, 64'h4, 64'd0, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_output !== exp_seq[0] || next_PC !== 64'h4) begin
                miscompares++;
                $display("FAIL b2b_stall[%0d]: got rdy=%b v=%b alu=%h npc=%h, need rdy=0 v=1 alu=2 npc=4",
                         k, in_ready, out_valid, alu_output, next_PC);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || alu_output !== exp_seq[0]) begin
            miscompares++;
            $display("FAIL b2b_release: got rdy=%b alu=%h, need rdy=1 alu=2", in_ready, alu_output);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || alu_output !== exp_seq[1] || next_PC !== 64'h8) begin
            miscompares++;
            $display("FAIL b2b_second: got v=%b alu=%h npc=%h, need v=1 alu=4 npc=8",
                     out_valid, alu_output, next_PC);
        end
        drive(4'b0000, 64'd3, 64'd3, 64'h8, 64'd0, 1'b0, 2'b00);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || alu_output !== exp_seq[2] || next_PC !== 64'hC) begin
            miscompares++;
            $display("FAIL b2b_third: got v=%b alu=%h npc=%h, need v=1 alu=6 npc=c",
                     out_valid, alu_output, next_PC);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got v=%b need 0 (duplicate output)", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(4'b0000, 64'd10, 64'd10, 64'h40, 64'd0, 1'b0, 2'b00);
        tick();
        drive(4'b0000, 64'd9, 64'd9, 64'h44, 64'd0, 1'b0, 2'b00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_stalled: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        drive(4'b0000, 64'd9, 64'd9, 64'h48, 64'd0, 1'b0, 2'b00);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop: got v=%b need 0", out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(4'b0000, 64'd20, 64'd22, 64'h80, 64'd0, 1'b0, 2'b00);
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || alu_output !== 64'd0 || next_PC !== 64'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got v=%b alu=%h npc=%h rdy=%b, need 0/0/0/1",
                     out_valid, alu_output, next_PC, in_ready);
        end
    endtask

`ifdef EXECUTE_PIPE_MUL_EN
    task automatic test_mul();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        drive(4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h200, 64'd8, 1'b1, 2'b01);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_accept: got rdy=%b need 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= XLEN; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mul_busy: %0d busy cycles showed rdy=1 or early valid, need 0", bad);
        end
        vectors++;
        if (out_valid !== 1'b1 || alu_output !== 64'hFFFF_FFFF_FFFF_FFFD || next_PC !== 64'h204 || branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_result: got v=%b alu=%h npc=%h bt=%b, need v=1 alu=fffffffffffffffd npc=204 bt=0",
                     out_valid, alu_output, next_PC, branch_taken);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        seen = 0;
        out_ready = 1'b1;
        drive(4'b1010, 64'd3, 64'd5, 64'h300, 64'd0, 1'b0, 2'b00);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_mul: got v=%b rdy=%b, need v=0 rdy=1", out_valid, in_ready);
        end
        for (int k = 0; k < XLEN + 4; k++) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL reset_mid_mul_stale: got %0d valid cycles, need 0", seen);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu_ops();
        test_branch();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
`ifdef EXECUTE_PIPE_MUL_EN
        test_mul();
        test_reset_mid_mul();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end within time limit");
        $fatal(1);
    end

endmodule
